hazard_scoreboard: RTL and testbench

//  Producer-side companion to the EX-stage forwarding unit in the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/hazard_scoreboard_if.sv | 28 ++
 rtl/hazard_scoreboard.sv | 47 ++++
 tb/tb_hazard_scoreboard.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and hazard/bypass response bundle between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              flush;
  logic              cnt_clr;
  logic              stall;
  logic              id_bypass_a;
  logic              id_bypass_b;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load, flush, cnt_clr,
    input  stall, id_bypass_a, id_bypass_b, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_is_load, flush, cnt_clr,
    output stall, id_bypass_a, id_bypass_b, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks EX/MEM/WB destination tags, raises load-use stalls, drives ID bypass selects, counts stalls.
module hazard_scoreboard #(
  parameter int ADDR_W         = 2,
  parameter int CNT_W          = 16,
  parameter bit HARDWIRED_ZERO = 0
) (
  input logic               clk,
  input logic               reset_n,
  hazard_scoreboard_if.slave sb
);
  logic              ex_v, ex_ld, mem_v, wb_v;
  logic [ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0]  cnt;
  logic              hit1, hit2, stall_c, issue;
  always_comb begin
    hit1    = ex_v && ex_ld && ex_rd == sb.id_rs1;
    hit2    = ex_v && ex_ld && ex_rd == sb.id_rs2;
    // reset_n gating lets an asynchronous reset drop stall before the slots settle
    stall_c = reset_n && sb.id_valid && !sb.flush && ((sb.id_use_rs1 && hit1) || (sb.id_use_rs2 && hit2));
    issue   = sb.id_valid && sb.id_reg_write && !stall_c && !sb.flush && !(HARDWIRED_ZERO && sb.id_rd == '0);
    sb.stall       = stall_c;
    sb.id_bypass_a = reset_n && sb.id_valid && sb.id_use_rs1 && wb_v && wb_rd == sb.id_rs1;
    sb.id_bypass_b = reset_n && sb.id_valid && sb.id_use_rs2 && wb_v && wb_rd == sb.id_rs2;
    sb.stall_cnt   = cnt;
  end
  // only the EX slot needs the load flag; MEM and WB carry valid and tag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
      cnt    <= '0;
    end else begin
      ex_v   <= issue;
      ex_rd  <= issue ? sb.id_rd : '0;
      ex_ld  <= issue && sb.id_is_load;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      cnt    <= sb.cnt_clr ? '0 : (stall_c && cnt != '1) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus checked against an issue-history model of the scoreboard.
module tb_hazard_scoreboard;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.ADDR_W(2), .CNT_W(16)) b16 ();
  hazard_scoreboard_if #(.ADDR_W(2), .CNT_W(2))  b2 ();
  assign b2.id_valid     = b16.id_valid;
  assign b2.id_rs1       = b16.id_rs1;
  assign b2.id_rs2       = b16.id_rs2;
  assign b2.id_use_rs1   = b16.id_use_rs1;
  assign b2.id_use_rs2   = b16.id_use_rs2;
  assign b2.id_rd        = b16.id_rd;
  assign b2.id_reg_write = b16.id_reg_write;
  assign b2.id_is_load   = b16.id_is_load;
  assign b2.flush        = b16.flush;
  assign b2.cnt_clr      = b16.cnt_clr;
  hazard_scoreboard #(.ADDR_W(2), .CNT_W(16), .HARDWIRED_ZERO(0)) u16 (.clk(clk), .reset_n(reset_n), .sb(b16));
  hazard_scoreboard #(.ADDR_W(2), .CNT_W(2),  .HARDWIRED_ZERO(0)) u2  (.clk(clk), .reset_n(reset_n), .sb(b2));

  typedef struct {bit v; bit [1:0] rd; bit ld;} rec_t;
  rec_t hist[$];
  int m_cnt16, m_cnt2;
  int vectors = 0, miscompares = 0;
  bit e_stall;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rec_t b = '{v: 0, rd: 0, ld: 0};
    hist = {b, b, b};
    m_cnt16 = 0;
    m_cnt2 = 0;
  endtask

  function automatic bit hit(bit [1:0] s);
    return hist[0].v && hist[0].ld && hist[0].rd == s;
  endfunction

  task automatic set_id(bit v, bit [1:0] rs1, bit [1:0] rs2, bit u1, bit u2, bit [1:0] rd, bit rw, bit ld, bit fl, bit clr);
    b16.id_valid = v; b16.id_rs1 = rs1; b16.id_rs2 = rs2; b16.id_use_rs1 = u1; b16.id_use_rs2 = u2;
    b16.id_rd = rd; b16.id_reg_write = rw; b16.id_is_load = ld; b16.flush = fl; b16.cnt_clr = clr;
  endtask

  task automatic check_comb();
    bit ea, eb;
    e_stall = b16.id_valid && !b16.flush &&
              ((b16.id_use_rs1 && hit(b16.id_rs1)) || (b16.id_use_rs2 && hit(b16.id_rs2)));
    ea = b16.id_valid && b16.id_use_rs1 && hist[2].v && hist[2].rd == b16.id_rs1;
    eb = b16.id_valid && b16.id_use_rs2 && hist[2].v && hist[2].rd == b16.id_rs2;
    chk("stall", 32'(b16.stall), 32'(e_stall));
    chk("bypass_a", 32'(b16.id_bypass_a), 32'(ea));
    chk("bypass_b", 32'(b16.id_bypass_b), 32'(eb));
  endtask

  task automatic tick();
    rec_t r;
    #1 check_comb();
    @(posedge clk);
    m_cnt16 = b16.cnt_clr ? 0 : (e_stall && m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
    m_cnt2  = b16.cnt_clr ? 0 : (e_stall && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    r.v  = b16.id_valid && b16.id_reg_write && !e_stall && !b16.flush;
    r.rd = r.v ? b16.id_rd : 2'd0;
    r.ld = r.v && b16.id_is_load;
    hist.push_front(r);
    void'(hist.pop_back());
    @(negedge clk);
    chk("cnt16", 32'(b16.stall_cnt), 32'(m_cnt16));
    chk("cnt2", 32'(b2.stall_cnt), 32'(m_cnt2));
    chk("ex_slot", {29'd0, u16.ex_v, u16.ex_rd, u16.ex_ld}, {29'd0, hist[0].v, hist[0].rd, hist[0].ld});
  endtask

  initial begin
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(b16.stall), 0);
    chk("rst_cnt", 32'(b16.stall_cnt), 0);
    chk("rst_ex", {29'd0, u16.ex_v, u16.ex_rd, u16.ex_ld}, 0);
    reset_n = 1;
    // load r1 then ADD r2,r1,r3
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 3, 1, 0, 2, 1, 0, 0, 0); tick();
    chk("t1_cnt", 32'(b16.stall_cnt), 1);
    chk("t1_bubble", 32'(u16.ex_v), 0);
    tick();
    chk("t1_issue", {29'd0, u16.ex_v, u16.ex_rd, u16.ex_ld}, 32'b1100);
    chk("t1_cnt_hold", 32'(b16.stall_cnt), 1);
    // ALU r2 then consumer of r2
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); tick();
    set_id(1, 2, 2, 1, 1, 3, 1, 0, 0, 0); #1 chk("t2_nostall", 32'(b16.stall), 0); tick();
    // write r3, two independent ops, consumer of r3 on rs2
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_id(1, 0, 3, 1, 1, 0, 1, 0, 0, 0); #1
    chk("t3_byp_b", 32'(b16.id_bypass_b), 1);
    chk("t3_byp_a", 32'(b16.id_bypass_a), 0);
    tick();
    // load r1, consumer arrives with flush
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 1, 1, 1, 2, 1, 0, 1, 0); #1 chk("t4_flush_nostall", 32'(b16.stall), 0); tick();
    chk("t4_ex_bubble", {29'd0, u16.ex_v, u16.ex_rd, u16.ex_ld}, 0);
    // async reset mid-stall
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 3, 1, 0, 2, 1, 0, 0, 0); #1 chk("t5_pre", 32'(b16.stall), 1);
    #1 reset_n = 0;
    #1 chk("t5_stall", 32'(b16.stall), 0);
    chk("t5_slots", {28'd0, u16.ex_v, u16.mem_v, u16.wb_v, u16.ex_ld}, 0);
    chk("t5_cnt", 32'(b16.stall_cnt), 0);
    model_reset();
    #1 reset_n = 1;
    @(negedge clk);
    // five load-use stalls saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
      set_id(1, 2, 1, 0, 1, 2, 1, 0, 0, 0); tick(); tick();
    end
    chk("t6_sat", 32'(b2.stall_cnt), 3);
    chk("t6_cnt16", 32'(b16.stall_cnt), 5);
    set_id(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    set_id(1, 1, 0, 1, 0, 2, 1, 0, 0, 1); #1 chk("t6_stall", 32'(b16.stall), 1); tick();
    chk("t6_clr", 32'(b2.stall_cnt), 0);
    // random traffic over a tiny register space so hits are frequent
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
